// File: rtl/store_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : store_write_ctrl
// Description : Sub-word store controller; byte/half stores read-merge-write,
//               word stores write directly. Option: STORE_MISALIGN_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module store_write_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  input  logic [31:0] mem_rd_data,
  output logic        mem_write,
  output logic [31:0] mem_wr_data,
  output logic        done,
  output logic        err
);

  localparam logic [1:0] c_size_byte = 2'b00;
  localparam logic [1:0] c_size_half = 2'b01;
  localparam logic [1:0] c_size_word = 2'b10;
  localparam logic [1:0] c_size_rsvd = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t      r_state;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [1:0]  r_size;
  logic        w_misalign;
  logic        w_reject;
  logic [31:0] w_merged;

`ifdef STORE_MISALIGN_TRAP_EN
  assign w_misalign = ((req_size == c_size_half) && req_addr[0]) ||
                      ((req_size == c_size_word) && (req_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_reject  = (req_size == c_size_rsvd) || w_misalign;
  assign req_ready = (r_state == S_IDLE);

  // Little-endian lane replacement over the word just read back
  always_comb begin
    w_merged = mem_rd_data;
    case (r_size)
      c_size_byte: begin
        case (r_addr[1:0])
          2'd0:    w_merged[7:0]   = r_data[7:0];
          2'd1:    w_merged[15:8]  = r_data[7:0];
          2'd2:    w_merged[23:16] = r_data[7:0];
          default: w_merged[31:24] = r_data[7:0];
        endcase
      end
      c_size_half: begin
        if (r_addr[1]) w_merged[31:16] = r_data[15:0];
        else           w_merged[15:0]  = r_data[15:0];
      end
      c_size_word: w_merged = r_data;
      default:     w_merged = mem_rd_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_data      <= '0;
      r_size      <= '0;
      mem_addr    <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_wr_data <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr <= req_addr;
            r_data <= req_data;
            r_size <= req_size;
            if (w_reject) begin
              r_state <= S_ERR;
              done    <= 1'b1;
              err     <= 1'b1;
            end else if (req_size == c_size_word) begin
              r_state     <= S_WRITE;
              mem_addr    <= {req_addr[31:2], 2'b00};
              mem_write   <= 1'b1;
              mem_wr_data <= req_data;
              done        <= 1'b1;
            end else begin
              r_state  <= S_READ;
              mem_addr <= {req_addr[31:2], 2'b00};
              mem_read <= 1'b1;
            end
          end
        end
        S_READ: begin
          r_state  <= S_WAIT;
          mem_addr <= {r_addr[31:2], 2'b00};
        end
        S_WAIT: begin
          r_state     <= S_WRITE;
          mem_addr    <= {r_addr[31:2], 2'b00};
          mem_write   <= 1'b1;
          mem_wr_data <= w_merged;
          done        <= 1'b1;
        end
        S_WRITE, S_ERR: begin
          r_state  <= S_IDLE;
          mem_addr <= '0;
        end
        default: begin
          r_state  <= S_IDLE;
          mem_addr <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_store_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_write_ctrl
// Description : Randomized self-checking bench for store_write_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_write_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic [31:0] mem_rd_data;
  logic        mem_write;
  logic [31:0] mem_wr_data;
  logic        done;
  logic        err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  store_write_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_size    (req_size),
    .mem_addr    (mem_addr),
    .mem_read    (mem_read),
    .mem_rd_data (mem_rd_data),
    .mem_write   (mem_write),
    .mem_wr_data (mem_wr_data),
    .done        (done),
    .err         (err)
  );

  // Reference: the stored word seen as four little-endian bytes
  function automatic logic [31:0] model_word(input logic [31:0] addr, input logic [31:0] data,
                                             input logic [1:0] size, input logic [31:0] rd);
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = rd[8*i +: 8];
    case (size)
      2'd0: b[addr[1:0]] = data[7:0];
      2'd1: begin
        b[{addr[1], 1'b0}] = data[7:0];
        b[{addr[1], 1'b1}] = data[15:8];
      end
      2'd2: return data;
      default: ;
    endcase
    return {b[3], b[2], b[1], b[0]};
  endfunction

  function automatic bit model_reject(input logic [31:0] addr, input logic [1:0] size);
    bit r;
    r = (size == 2'd3);
`ifdef STORE_MISALIGN_TRAP_EN
    if (size == 2'd1 && addr[0]) r = 1'b1;
    if (size == 2'd2 && addr[1:0] != 2'd0) r = 1'b1;
`endif
    return r;
  endfunction

  // Issue one request, observe 5 cycles, compare with the reference schedule
  task automatic run_req(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size,
                         input logic [31:0] rd, input string name, output logic [31:0] wd_seen);
    logic        o_rd [6];
    logic        o_wr [6];
    logic        o_dn [6];
    logic        o_er [6];
    logic        o_ry [6];
    logic [31:0] o_ad [6];
    logic [31:0] o_wd [6];
    bit          rej;
    int          lat;
    bit          prev;
    logic [31:0] exp_wd;
    rej    = model_reject(addr, size);
    lat    = (rej || size == 2'd2) ? 1 : 3;
    exp_wd = model_word(addr, data, size, rd);
    wd_seen = 32'hx;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s ready_idle: got %b expected 1", name, req_ready);
    end
    req_valid   = 1'b1;
    req_addr    = addr;
    req_data    = data;
    req_size    = size;
    mem_rd_data = $urandom;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_data  = $urandom;
    req_size  = 2'($urandom);
    prev = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      o_rd[c] = mem_read;  o_wr[c] = mem_write; o_dn[c] = done;
      o_er[c] = err;       o_ry[c] = req_ready; o_ad[c] = mem_addr;
      o_wd[c] = mem_wr_data;
      if (mem_read) begin
        mem_rd_data = rd;
        prev = 1'b1;
      end else if (prev) begin
        prev = 1'b0;
      end else begin
        mem_rd_data = $urandom;
      end
    end
    for (int c = 1; c <= 5; c++) begin
      logic e_rd, e_wr, e_dn, e_er, e_ry;
      e_rd = !rej && size != 2'd2 && c == 1;
      e_wr = !rej && c == lat;
      e_dn = (c == lat);
      e_er = rej && c == 1;
      e_ry = (c > lat);
      tests += 5;
      if (o_rd[c] !== e_rd) begin fails++; $display("FAIL %s mem_read cyc%0d: got %b expected %b", name, c, o_rd[c], e_rd); end
      if (o_wr[c] !== e_wr) begin fails++; $display("FAIL %s mem_write cyc%0d: got %b expected %b", name, c, o_wr[c], e_wr); end
      if (o_dn[c] !== e_dn) begin fails++; $display("FAIL %s done cyc%0d: got %b expected %b", name, c, o_dn[c], e_dn); end
      if (o_er[c] !== e_er) begin fails++; $display("FAIL %s err cyc%0d: got %b expected %b", name, c, o_er[c], e_er); end
      if (o_ry[c] !== e_ry) begin fails++; $display("FAIL %s req_ready cyc%0d: got %b expected %b", name, c, o_ry[c], e_ry); end
      if (!rej && c <= lat) begin
        tests++;
        if (o_ad[c] !== {addr[31:2], 2'b00}) begin
          fails++;
          $display("FAIL %s mem_addr cyc%0d: got %h expected %h", name, c, o_ad[c], {addr[31:2], 2'b00});
        end
      end else if (c > lat) begin
        tests++;
        if (o_ad[c] !== 32'h0) begin
          fails++;
          $display("FAIL %s mem_addr_idle cyc%0d: got %h expected 0", name, c, o_ad[c]);
        end
      end
      if (e_wr) begin
        tests++;
        wd_seen = o_wd[c];
        if (o_wd[c] !== exp_wd) begin
          fails++;
          $display("FAIL %s mem_wr_data cyc%0d: got %h expected %h", name, c, o_wd[c], exp_wd);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0; mem_rd_data = '0;
    repeat (3) @(negedge clk);
    tests++;
    if ({mem_read, mem_write, done, err, mem_addr, mem_wr_data} !== 68'h0) begin
      fails++;
      $display("FAIL reset_outputs: got rd=%b wr=%b dn=%b er=%b ad=%h wd=%h expected all 0",
               mem_read, mem_write, done, err, mem_addr, mem_wr_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_word();
    logic [31:0] wd;
    run_req(32'h100, 32'hDEADBEEF, 2'd2, $urandom, "word", wd);
    tests++;
    if (wd !== 32'hDEADBEEF) begin fails++; $display("FAIL word_const: got %h expected deadbeef", wd); end
  endtask

  task automatic test_byte();
    logic [31:0] wd;
    run_req(32'h203, 32'h000000AB, 2'd0, 32'h11223344, "byte", wd);
    tests++;
    if (wd !== 32'hAB223344) begin fails++; $display("FAIL byte_const: got %h expected ab223344", wd); end
  endtask

  task automatic test_half();
    logic [31:0] wd;
    run_req(32'h302, 32'h0000CAFE, 2'd1, 32'h11223344, "half", wd);
    tests++;
    if (wd !== 32'hCAFE3344) begin fails++; $display("FAIL half_const: got %h expected cafe3344", wd); end
  endtask

  task automatic test_reserved();
    logic [31:0] wd;
    run_req(32'h0, $urandom, 2'd3, $urandom, "reserved", wd);
  endtask

  task automatic test_misalign();
    logic [31:0] wd;
    run_req(32'h102, 32'h12345678, 2'd2, $urandom, "mis_word", wd);
    run_req(32'h301, 32'h0000BEEF, 2'd1, 32'hA5A5A5A5, "mis_half", wd);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h400; req_data = 32'h01020304; req_size = 2'd2;
    @(posedge clk);
    #1;
    req_addr = 32'h804; req_data = 32'hA0B0C0D0;
    @(negedge clk);
    tests += 3;
    if (mem_write !== 1'b1) begin fails++; $display("FAIL b2b_wr1: got %b expected 1", mem_write); end
    if (mem_wr_data !== 32'h01020304) begin fails++; $display("FAIL b2b_wd1: got %h expected 01020304", mem_wr_data); end
    if (req_ready !== 1'b0) begin fails++; $display("FAIL b2b_ready_done: got %b expected 0", req_ready); end
    @(negedge clk);
    tests++;
    if (mem_write !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b_gap: got wr=%b ready=%b expected wr=0 ready=1", mem_write, req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    tests += 2;
    if (mem_write !== 1'b1 || mem_wr_data !== 32'hA0B0C0D0) begin
      fails++;
      $display("FAIL b2b_wr2: got wr=%b wd=%h expected wr=1 wd=a0b0c0d0", mem_write, mem_wr_data);
    end
    if (mem_addr !== 32'h804) begin fails++; $display("FAIL b2b_addr2: got %h expected 00000804", mem_addr); end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int bad;
    logic [31:0] wd;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h203; req_data = 32'hAB; req_size = 2'd0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (mem_read !== 1'b1) begin fails++; $display("FAIL abort_read: got %b expected 1", mem_read); end
    mem_rd_data = 32'h11223344;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({mem_read, mem_write, done, err, mem_addr, mem_wr_data} !== 68'h0) begin
      fails++;
      $display("FAIL abort_outputs: got rd=%b wr=%b dn=%b er=%b ad=%h wd=%h expected all 0",
               mem_read, mem_write, done, err, mem_addr, mem_wr_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (mem_write !== 1'b0 || done !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL abort_no_write: got %0d bad cycles expected 0", bad); end
    run_req(32'h205, 32'h0000005A, 2'd0, 32'hFFEEDDCC, "after_abort", wd);
  endtask

  task automatic test_random();
    logic [31:0] wd;
    for (int i = 0; i < 150; i++) begin
      run_req($urandom, $urandom, 2'($urandom_range(0, 3)), $urandom, "random", wd);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_reserved();
    test_misalign();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
